johnson_decoder: RTL and testbench
==================================

// Module: johnson_decoder
// PURPOSE
//   Receive-side companion to the Johnson counter: samples a WIDTH-bit Johnson code
//   stream and decodes each code to its binary position 0..2*WIDTH-1. Checks that
//   every code is legal and that the code sequence advances correctly.
//   Acquires lock after LOCK_COUNT consecutive correct steps.
//   Reports errors and keeps a saturating error count for system monitoring.
// PARAMETERS
//   WIDTH       4  Johnson code width; the sequence has 2*WIDTH states.
//   LOCK_COUNT  3  Consecutive correct successor steps required to enter LOCK (>=1).
//   ERR_W       8  Width of the saturating error counter.
// PORTS
//   clk         in   1                      Rising-edge clock.
//   rst_n       in   1                      Asynchronous reset, active low.
//   in_valid    in   1                      code_in is sampled this cycle.
//   code_in     in   WIDTH                  Johnson code; code_in[WIDTH-1] is the first bit filled.
//   index       out  IW=$clog2(2*WIDTH)     Decoded position of the last legal code.
//   index_valid out  1                      1-cycle pulse: index updated.
//   locked      out  1                      High while the FSM is in LOCK.
//   err_illegal out  1                      1-cycle pulse: sampled code is not a Johnson code.
//   err_seq     out  1                      1-cycle pulse: legal code, but not the successor and not a repeat.
//   err_count   out  ERR_W                  Saturating count of err_illegal plus err_seq events.
// BEHAVIOUR
//   Reset (async, rst_n=0): all outputs 0; state=SEARCH; prev_idx=0; run=0.
//   All outputs are registered. Each output reflects the sample taken on the
//   previous rising edge (1-cycle latency). When in_valid=0: pulses are 0 and no
//   state changes.
//   Legality rule: count adjacent bit pairs (MSB..LSB) that differ. The code is
//   legal iff this count <= 1. For WIDTH=4 the legal set is exactly these 8 codes:
//   0000 1000 1100 1110 1111 0111 0011 0001.
//   Decode rule: p = popcount(code_in).
//     - If code_in==0 or code_in[WIDTH-1]==1: idx = p.
//     - Otherwise: idx = 2*WIDTH - p.
//     - Examples: 1110 -> 3, 0111 -> 5, 0001 -> 7.
//   Successor: succ = (prev_idx+1) mod 2*WIDTH. Wrap-around: 7 -> 0 is a correct step.
//   Repeat: idx == prev_idx. A repeat is a stall. It is not an error, run is
//   unchanged, and index_valid still pulses.
//   FSM, evaluated only on in_valid=1:
//     SEARCH:
//       - Illegal code: err_illegal, stay in SEARCH.
//       - Legal code: index<=idx, prev_idx<=idx, run<=0, go to ACQ.
//     ACQ:
//       - Successor: run<=run+1. If run+1==LOCK_COUNT, go to LOCK and set run<=0.
//       - Repeat: hold.
//       - Legal non-successor: err_seq, run<=0, prev_idx<=idx, stay in ACQ.
//       - Illegal code: err_illegal, go to SEARCH.
//     LOCK:
//       - Successor or repeat: stay in LOCK.
//       - Legal non-successor: err_seq, go to ACQ with run<=0 and prev_idx<=idx.
//       - Illegal code: err_illegal, go to SEARCH.
//   Every legal sample updates index and prev_idx and pulses index_valid.
//   Illegal samples leave index and prev_idx unchanged.
//   locked=1 exactly while the state is LOCK. It drops on the cycle after the
//   faulting sample.
//   err_illegal and err_seq are mutually exclusive per cycle. err_count increments
//   by 1 per error and holds at 2^ERR_W-1.
//   Reset asserted mid-stream clears everything immediately. After release,
//   acquisition restarts from SEARCH.
// TESTING
//   Reset, then feed 0000,1000,1100,1110 with in_valid=1 every cycle ->
//     index 0,1,2,3; locked=1 on the cycle after 1110; no error pulses.
//   While locked, feed 1111,0111,0011,0001,0000 ->
//     index 4,5,6,7,0; wrap-around accepted; locked stays 1.
//   While locked, insert 0110 ->
//     err_illegal=1 for 1 cycle; locked=0 next cycle; index held; err_count=1.
//   While locked at index 2, feed 1111 (index 4) ->
//     err_seq=1; state ACQ; index=4; locked=0. Then 0111,0011,0001 -> relock.
//   Repeat 1100 three times, and also toggle in_valid=0 gaps, while locked ->
//     no errors; locked stays 1; index_valid pulses only on in_valid=1 cycles.
//   Drive 300 illegal codes with ERR_W=8 -> err_count saturates at 255.
//   Assert rst_n mid-lock -> all outputs 0 at once.

Source files
------------

// File: rtl/johnson_decoder.sv
// rtl/johnson_decoder.sv - Johnson code stream decoder with sequence checking, lock tracking and error counting
module johnson_decoder #(
   parameter int WIDTH      = 4,
   parameter int LOCK_COUNT = 3,
   parameter int ERR_W      = 8,
   localparam int IW        = $clog2(2*WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] code_in,
   output logic [IW-1:0]    index,
   output logic             index_valid,
   output logic             locked,
   output logic             err_illegal,
   output logic             err_seq,
   output logic [ERR_W-1:0] err_count
);
   localparam int N  = 2*WIDTH;
   localparam int RW = $clog2(LOCK_COUNT+1);

   typedef enum logic [1:0] {SEARCH, ACQ, LOCK} state_t;

   state_t        state;
   logic [IW-1:0] prev_idx;
   logic [RW-1:0] run;

   int unsigned   trans;
   int unsigned   pop;
   int unsigned   idx_i;
   logic          legal;
   logic          is_succ;
   logic          is_rep;
   logic          err_evt;
   logic [IW-1:0] idx;
   logic [IW-1:0] succ;

   // A Johnson code has at most one boundary between its run of ones and run of zeros.
   always_comb begin
      trans = 0;
      pop   = 0;
      for (int i = 0; i < WIDTH-1; i++)
         if (code_in[i] != code_in[i+1]) trans = trans + 1;
      for (int i = 0; i < WIDTH; i++)
         if (code_in[i]) pop = pop + 1;
      legal   = (trans <= 1);
      idx_i   = (code_in == '0 || code_in[WIDTH-1]) ? pop : unsigned'(N) - pop;
      idx     = idx_i[IW-1:0];
      succ    = (prev_idx == IW'(N-1)) ? '0 : prev_idx + 1'b1;
      is_succ = (idx == succ);
      is_rep  = (idx == prev_idx);
      err_evt = in_valid && (!legal || (state != SEARCH && !is_succ && !is_rep));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= SEARCH;
         prev_idx    <= '0;
         run         <= '0;
         index       <= '0;
         index_valid <= 1'b0;
         locked      <= 1'b0;
         err_illegal <= 1'b0;
         err_seq     <= 1'b0;
         err_count   <= '0;
      end else begin
         index_valid <= 1'b0;
         err_illegal <= 1'b0;
         err_seq     <= 1'b0;
         if (err_evt && err_count != '1)
            err_count <= err_count + 1'b1;
         if (in_valid) begin
            if (!legal) begin
               err_illegal <= 1'b1;
               state       <= SEARCH;
               run         <= '0;
               locked      <= 1'b0;
            end else begin
               index       <= idx;
               prev_idx    <= idx;
               index_valid <= 1'b1;
               case (state)
                  SEARCH: begin
                     state  <= ACQ;
                     run    <= '0;
                     locked <= 1'b0;
                  end
                  ACQ: begin
                     if (is_succ) begin
                        if (int'(run) + 1 == LOCK_COUNT) begin
                           state  <= LOCK;
                           run    <= '0;
                           locked <= 1'b1;
                        end else begin
                           run <= run + 1'b1;
                        end
                     end else if (!is_rep) begin
                        err_seq <= 1'b1;
                        run     <= '0;
                     end
                  end
                  LOCK: begin
                     // A stall (repeat) keeps lock; only a jump breaks it.
                     if (!is_succ && !is_rep) begin
                        err_seq <= 1'b1;
                        state   <= ACQ;
                        run     <= '0;
                        locked  <= 1'b0;
                     end
                  end
                  default: begin
                     state  <= SEARCH;
                     run    <= '0;
                     locked <= 1'b0;
                  end
               endcase
            end
         end
      end
   end
endmodule

// File: tb/tb_johnson_decoder.sv
// tb/tb_johnson_decoder.sv - scoreboard bench for johnson_decoder against a table-driven reference model
module tb_johnson_decoder;
   localparam int W  = 4;
   localparam int LC = 3;
   localparam int EW = 8;
   localparam int N  = 2*W;
   localparam int IW = $clog2(N);

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          in_valid = 1'b0;
   logic [W-1:0]  code_in = '0;
   logic [IW-1:0] index;
   logic          index_valid;
   logic          locked;
   logic          err_illegal;
   logic          err_seq;
   logic [EW-1:0] err_count;

   always #5 clk = ~clk;

   johnson_decoder #(.WIDTH(W), .LOCK_COUNT(LC), .ERR_W(EW)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .code_in(code_in),
      .index(index), .index_valid(index_valid), .locked(locked),
      .err_illegal(err_illegal), .err_seq(err_seq), .err_count(err_count)
   );

   typedef struct {
      int cyc; int iv; int idx; int lk; int ei; int es; int ec;
   } exp_t;

   exp_t         q[$];
   exp_t         last;
   int           checks = 0;
   int           passes = 0;
   int           cyc = 0;
   int           code2idx[int];
   logic [W-1:0] seqc[N];
   int           ill[$];
   int           m_state, m_prev, m_run, m_idx, m_ec;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act == exp) passes++;
      else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
   endtask

   // Reference: the legal codes are exactly the states a Johnson counter walks through.
   task automatic build_table();
      logic [W-1:0] c;
      c = '0;
      for (int k = 0; k < N; k++) begin
         seqc[k] = c;
         code2idx[int'(c)] = k;
         c = {~c[0], c[W-1:1]};
      end
      for (int v = 0; v < (1 << W); v++)
         if (!code2idx.exists(v)) ill.push_back(v);
   endtask

   task automatic model_reset();
      m_state = 0; m_prev = 0; m_run = 0; m_idx = 0; m_ec = 0;
      q.delete();
      last = '{default: 0};
   endtask

   task automatic model_step(input logic [W-1:0] c, output exp_t e);
      int k;
      e = '{default: 0};
      if (!code2idx.exists(int'(c))) begin
         e.ei = 1;
         m_state = 0;
      end else begin
         k = code2idx[int'(c)];
         e.iv = 1;
         if (m_state == 0) begin
            m_state = 1; m_run = 0;
         end else if (k == (m_prev + 1) % N) begin
            if (m_state == 1) begin
               m_run++;
               if (m_run == LC) begin m_state = 2; m_run = 0; end
            end
         end else if (k != m_prev) begin
            e.es = 1; m_state = 1; m_run = 0;
         end
         m_prev = k;
         m_idx = k;
      end
      if ((e.ei != 0 || e.es != 0) && m_ec < (1 << EW) - 1) m_ec++;
      e.idx = m_idx;
      e.lk  = (m_state == 2) ? 1 : 0;
      e.ec  = m_ec;
   endtask

   task automatic send(input logic [W-1:0] c);
      exp_t e;
      @(posedge clk); #1;
      in_valid = 1'b1;
      code_in = c;
      model_step(c, e);
      e.cyc = cyc + 1;
      q.push_back(e);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
         in_valid = 1'b0;
         code_in = W'($urandom);
      end
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_index"}, int'(index), 0);
      chk({tag, "_index_valid"}, int'(index_valid), 0);
      chk({tag, "_locked"}, int'(locked), 0);
      chk({tag, "_err_illegal"}, int'(err_illegal), 0);
      chk({tag, "_err_seq"}, int'(err_seq), 0);
      chk({tag, "_err_count"}, int'(err_count), 0);
   endtask

   // Monitor: every output event consumes one scoreboard entry due on this cycle.
   always @(negedge clk) begin
      exp_t e;
      if (rst_n) begin
         if (index_valid || err_illegal || err_seq) begin
            if (q.size() == 0 || q[0].cyc != cyc) begin
               checks++;
               $display("FAIL unexpected_event: got iv=%0d ei=%0d es=%0d expected no event (cycle %0d)",
                        index_valid, err_illegal, err_seq, cyc);
            end else begin
               e = q.pop_front();
               chk("index_valid", int'(index_valid), e.iv);
               chk("err_illegal", int'(err_illegal), e.ei);
               chk("err_seq", int'(err_seq), e.es);
               chk("index", int'(index), e.idx);
               chk("locked", int'(locked), e.lk);
               chk("err_count", int'(err_count), e.ec);
               last = e;
            end
         end else begin
            if (q.size() != 0 && q[0].cyc <= cyc) begin
               checks++;
               $display("FAIL missing_event: got no event expected iv=%0d ei=%0d es=%0d (cycle %0d)",
                        q[0].iv, q[0].ei, q[0].es, cyc);
               last = q.pop_front();
            end
            chk("idle_locked", int'(locked), last.lk);
            chk("idle_index", int'(index), last.idx);
            chk("idle_err_count", int'(err_count), last.ec);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int r, k;
      build_table();
      model_reset();
      repeat (2) @(posedge clk);
      #1 check_zero("reset");
      rst_n = 1'b1;

      // Acquire and lock, then run through the wrap-around.
      send(4'b0000); send(4'b1000); send(4'b1100); send(4'b1110);
      idle(1);
      chk("locked_after_1110", int'(locked), 1);
      send(4'b1111); send(4'b0111); send(4'b0011); send(4'b0001); send(4'b0000);
      idle(1);
      chk("locked_after_wrap", int'(locked), 1);

      // Illegal code breaks lock and counts once.
      send(4'b0110);
      idle(2);
      chk("locked_after_illegal", int'(locked), 0);
      chk("count_after_illegal", int'(err_count), 1);
      chk("index_held", int'(index), 0);

      // Lock at index 2, then jump to 4 and relock.
      send(4'b0001); send(4'b0000); send(4'b1000); send(4'b1100);
      send(4'b1111); send(4'b0111); send(4'b0011); send(4'b0001);
      idle(1);
      chk("relocked", int'(locked), 1);

      // Stalls and gaps while locked.
      send(4'b0000); send(4'b1000); send(4'b1100);
      idle(1); send(4'b1100); idle(2); send(4'b1100); send(4'b1110);
      idle(1);
      chk("locked_after_stalls", int'(locked), 1);

      // Saturate the error counter.
      for (int i = 0; i < 300; i++) send(W'(ill[$urandom_range(ill.size()-1)]));
      idle(2);
      chk("err_count_saturated", int'(err_count), (1 << EW) - 1);

      // Reset while locked.
      do_reset_cycle();

      // Randomized stream.
      for (int i = 0; i < 600; i++) begin
         r = $urandom_range(99);
         if (r < 55) send(seqc[(m_prev + 1) % N]);
         else if (r < 70) send(seqc[m_prev]);
         else if (r < 80) begin k = $urandom_range(N-1); send(seqc[k]); end
         else if (r < 90) send(W'(ill[$urandom_range(ill.size()-1)]));
         else idle($urandom_range(1, 3));
      end
      idle(3);
      checks++;
      if (q.size() == 0) passes++;
      else $display("FAIL drain: got %0d pending entries expected 0", q.size());

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

   task automatic do_reset_cycle();
      rst_n = 1'b1;
      send(4'b0000); send(4'b1000); send(4'b1100); send(4'b1110);
      idle(2);
      chk("locked_before_reset", int'(locked), 1);
      send(4'b1111);
      #3 rst_n = 1'b0;
      #1 check_zero("midreset");
      model_reset();
      in_valid = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      send(4'b0011); send(4'b0001); send(4'b0000); send(4'b1000);
      idle(1);
      chk("relock_after_reset", int'(locked), 1);
   endtask
endmodule
